// File: rtl/mutative_setup_ctrl_if.sv
// Signal bundle between the associativity reconfiguration controller and the cache.
// master = controller (drives mode, stall and flush requests), slave = cache datapath/FSM.
interface mutative_setup_ctrl_if #(
   parameter int SET_BITS     = 4,
   parameter int WAY_IDX_BITS = 3
);
   // access monitoring, one pulse per completed CPU transaction
   logic                    access_valid;
   logic                    access_hit;

   // cache status and software override
   logic                    cache_idle;
   logic                    force_valid;
   logic [1:0]              force_setup;

   // mode and change-over control
   logic [1:0]              setup;
   logic                    cpu_stall;
   logic                    busy;

   // per-line flush handshake
   logic                    flush_valid;
   logic [SET_BITS-1:0]     flush_set;
   logic [WAY_IDX_BITS-1:0] flush_way;
   logic                    flush_done;

   modport master (
      input  access_valid, access_hit, cache_idle, force_valid, force_setup, flush_done,
      output setup, cpu_stall, busy, flush_valid, flush_set, flush_way
   );

   modport slave (
      output access_valid, access_hit, cache_idle, force_valid, force_setup, flush_done,
      input  setup, cpu_stall, busy, flush_valid, flush_set, flush_way
   );
endinterface

// File: rtl/mutative_setup_ctrl.sv
// Epoch miss counter that picks the cache associativity mode and sequences a stall/drain/flush/switch change-over.
// All outputs registered; each flush line is held until flush_done (min 1 cycle per line), CPU stalled throughout.
module mutative_setup_ctrl #(
   parameter int SET_BITS     = 4,
   parameter int WAY_IDX_BITS = 3,
   parameter int EPOCH_LEN    = 1024,
   parameter int MISS_HI      = 128,
   parameter int MISS_LO      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   mutative_setup_ctrl_if.master cif
);
   localparam int ACC_W  = $clog2(EPOCH_LEN);
   localparam int MISS_W = ACC_W + 1;

   localparam logic [ACC_W-1:0]        ACC_LAST  = ACC_W'(EPOCH_LEN - 1);
   localparam logic [MISS_W-1:0]       MISS_HI_V = MISS_W'(MISS_HI);
   localparam logic [MISS_W-1:0]       MISS_LO_V = MISS_W'(MISS_LO);
   localparam logic [SET_BITS-1:0]     SET_LAST  = '1;
   localparam logic [WAY_IDX_BITS-1:0] WAY_LAST  = '1;

   typedef enum logic [1:0] {
      S_COUNT  = 2'd0,
      S_DRAIN  = 2'd1,
      S_FLUSH  = 2'd2,
      S_SWITCH = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic [ACC_W-1:0]        acc_cnt_q, acc_cnt_d;
   logic [MISS_W-1:0]       miss_cnt_q, miss_cnt_d;
   logic [1:0]              setup_q, setup_d;
   logic [1:0]              target_q, target_d;
   logic                    cpu_stall_q, cpu_stall_d;
   logic                    flush_valid_q, flush_valid_d;
   logic                    busy_q, busy_d;
   logic [SET_BITS-1:0]     flush_set_q, flush_set_d;
   logic [WAY_IDX_BITS-1:0] flush_way_q, flush_way_d;

   logic                    epoch_close;
   logic                    last_line;
   logic [MISS_W-1:0]       miss_total;
   logic [1:0]              close_target;

   // Epoch decision: the closing access itself is part of the miss total.
   always_comb begin
      epoch_close  = cif.access_valid && (acc_cnt_q == ACC_LAST);
      miss_total   = miss_cnt_q + {{(MISS_W-1){1'b0}}, ~cif.access_hit};
      close_target = setup_q;
      if ((miss_total > MISS_HI_V) && (setup_q != 2'd3)) begin
         close_target = setup_q + 2'd1;
      end else if ((miss_total < MISS_LO_V) && (setup_q != 2'd0)) begin
         close_target = setup_q - 2'd1;
      end
      last_line = (flush_set_q == SET_LAST) && (flush_way_q == WAY_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_COUNT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_COUNT: begin
            if (cif.force_valid) begin
               if (cif.force_setup != setup_q) state_d = S_DRAIN;
            end else if (epoch_close && (close_target != setup_q)) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (cif.cache_idle) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            if (cif.flush_done && last_line) state_d = S_SWITCH;
         end
         S_SWITCH: begin
            state_d = S_COUNT;
         end
         default: state_d = S_COUNT;
      endcase
   end

   always_comb begin
      acc_cnt_d   = acc_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      target_d    = target_q;
      setup_d     = setup_q;
      flush_set_d = flush_set_q;
      flush_way_d = flush_way_q;

      unique case (state_q)
         S_COUNT: begin
            // A software override discards any epoch decision taken in the same cycle.
            if (cif.force_valid) begin
               target_d   = cif.force_setup;
               acc_cnt_d  = '0;
               miss_cnt_d = '0;
            end else if (epoch_close) begin
               target_d   = close_target;
               acc_cnt_d  = '0;
               miss_cnt_d = '0;
            end else if (cif.access_valid) begin
               acc_cnt_d  = acc_cnt_q + 1'b1;
               miss_cnt_d = miss_cnt_q + {{(MISS_W-1){1'b0}}, ~cif.access_hit};
            end
         end
         S_DRAIN: begin
            if (cif.cache_idle) begin
               flush_set_d = '0;
               flush_way_d = '0;
            end
         end
         S_FLUSH: begin
            // Set-major walk: all ways of a set before moving to the next set.
            if (cif.flush_done) begin
               if (last_line) begin
                  flush_set_d = '0;
                  flush_way_d = '0;
               end else if (flush_way_q == WAY_LAST) begin
                  flush_way_d = '0;
                  flush_set_d = flush_set_q + 1'b1;
               end else begin
                  flush_way_d = flush_way_q + 1'b1;
               end
            end
         end
         S_SWITCH: begin
            setup_d = target_q;
         end
         default: ;
      endcase

      cpu_stall_d   = (state_d != S_COUNT);
      busy_d        = (state_d != S_COUNT);
      flush_valid_d = (state_d == S_FLUSH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_cnt_q     <= '0;
         miss_cnt_q    <= '0;
         setup_q       <= 2'd3;
         target_q      <= 2'd3;
         cpu_stall_q   <= 1'b0;
         flush_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         flush_set_q   <= '0;
         flush_way_q   <= '0;
      end else begin
         acc_cnt_q     <= acc_cnt_d;
         miss_cnt_q    <= miss_cnt_d;
         setup_q       <= setup_d;
         target_q      <= target_d;
         cpu_stall_q   <= cpu_stall_d;
         flush_valid_q <= flush_valid_d;
         busy_q        <= busy_d;
         flush_set_q   <= flush_set_d;
         flush_way_q   <= flush_way_d;
      end
   end

   assign cif.setup       = setup_q;
   assign cif.cpu_stall   = cpu_stall_q;
   assign cif.busy        = busy_q;
   assign cif.flush_valid = flush_valid_q;
   assign cif.flush_set   = flush_set_q;
   assign cif.flush_way   = flush_way_q;

   a_flush_implies_stall: assert property (@(posedge clk) disable iff (rst)
      flush_valid_q |-> cpu_stall_q);
   a_busy_tracks_state: assert property (@(posedge clk) disable iff (rst)
      busy_q == (state_q != S_COUNT));
endmodule

// File: tb/tb_mutative_setup_ctrl.sv
// Directed bench for mutative_setup_ctrl at small epoch/cache sizes (16-access epochs, 4 sets x 8 ways).
module tb_mutative_setup_ctrl;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   mutative_setup_ctrl_if #(.SET_BITS(2), .WAY_IDX_BITS(3)) cif ();

   mutative_setup_ctrl #(
      .SET_BITS    (2),
      .WAY_IDX_BITS(3),
      .EPOCH_LEN   (16),
      .MISS_HI     (8),
      .MISS_LO     (2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cif(cif.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_accesses(input int n, input int misses);
      for (int i = 0; i < n; i++) begin
         cif.access_valid = 1'b1;
         cif.access_hit   = (i >= misses);
         step();
      end
      cif.access_valid = 1'b0;
      cif.access_hit   = 1'b0;
   endtask

   task automatic test_reset();
      rst              = 1'b1;
      cif.access_valid = 1'b0;
      cif.access_hit   = 1'b0;
      cif.cache_idle   = 1'b0;
      cif.force_valid  = 1'b0;
      cif.force_setup  = 2'd0;
      cif.flush_done   = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      checks++;
      if ({cif.setup, cif.cpu_stall, cif.flush_valid, cif.busy, cif.flush_set, cif.flush_way} !== 10'b11_0_0_0_00_000) begin
         errors++;
         $display("FAIL reset_values: got %b want %b",
                  {cif.setup, cif.cpu_stall, cif.flush_valid, cif.busy, cif.flush_set, cif.flush_way}, 10'b11_0_0_0_00_000);
      end
      // Enter DRAIN (cache_idle low keeps it there), then reset between edges.
      cif.force_valid = 1'b1;
      cif.force_setup = 2'd0;
      step();
      cif.force_valid = 1'b0;
      checks++;
      if ({cif.setup, cif.cpu_stall, cif.flush_valid, cif.busy} !== 5'b11_1_0_1) begin
         errors++;
         $display("FAIL reset_pre_drain: got %b want %b", {cif.setup, cif.cpu_stall, cif.flush_valid, cif.busy}, 5'b11_1_0_1);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({cif.setup, cif.cpu_stall, cif.flush_valid, cif.busy} !== 5'b11_0_0_0) begin
         errors++;
         $display("FAIL reset_async: got %b want %b", {cif.setup, cif.cpu_stall, cif.flush_valid, cif.busy}, 5'b11_0_0_0);
      end
      #1;
      rst = 1'b0;
      step();
      step();
      checks++;
      if ({cif.setup, cif.cpu_stall, cif.busy} !== 4'b11_0_0) begin
         errors++;
         $display("FAIL reset_release: got %b want %b", {cif.setup, cif.cpu_stall, cif.busy}, 4'b11_0_0);
      end
   endtask

   task automatic test_threshold_hi_at_max();
      run_accesses(16, 9);
      checks++;
      if ({cif.setup, cif.cpu_stall, cif.busy} !== 4'b11_0_0) begin
         errors++;
         $display("FAIL hi_at_max: got %b want %b", {cif.setup, cif.cpu_stall, cif.busy}, 4'b11_0_0);
      end
      checks++;
      if ({dut.acc_cnt_q, dut.miss_cnt_q} !== 9'd0) begin
         errors++;
         $display("FAIL hi_at_max_counters: got acc %0d miss %0d want 0 0", dut.acc_cnt_q, dut.miss_cnt_q);
      end
   endtask

   task automatic test_collision_epoch();
      // 15 hits, then the closing hit together with a no-op force: the would-be lowering is dropped.
      run_accesses(15, 0);
      cif.access_valid = 1'b1;
      cif.access_hit   = 1'b1;
      cif.force_valid  = 1'b1;
      cif.force_setup  = 2'd3;
      step();
      cif.access_valid = 1'b0;
      cif.force_valid  = 1'b0;
      checks++;
      if ({cif.setup, cif.cpu_stall, cif.busy} !== 4'b11_0_0) begin
         errors++;
         $display("FAIL collision_epoch: got %b want %b", {cif.setup, cif.cpu_stall, cif.busy}, 4'b11_0_0);
      end
      checks++;
      if ({dut.acc_cnt_q, dut.miss_cnt_q} !== 9'd0) begin
         errors++;
         $display("FAIL collision_counters: got acc %0d miss %0d want 0 0", dut.acc_cnt_q, dut.miss_cnt_q);
      end
      step();
      step();
      checks++;
      if ({cif.setup, cif.cpu_stall} !== 3'b11_0) begin
         errors++;
         $display("FAIL collision_settle: got %b want %b", {cif.setup, cif.cpu_stall}, 3'b11_0);
      end
   endtask

   task automatic test_lower();
      logic [1:0] es;
      logic [2:0] ew;
      cif.cache_idle = 1'b0;
      cif.flush_done = 1'b1;
      run_accesses(15, 1);
      checks++;
      if (cif.cpu_stall !== 1'b0) begin
         errors++;
         $display("FAIL lower_pre_close: got stall %b want 0", cif.cpu_stall);
      end
      run_accesses(1, 0);
      checks++;
      if ({cif.setup, cif.cpu_stall, cif.flush_valid, cif.busy} !== 5'b11_1_0_1) begin
         errors++;
         $display("FAIL lower_stall_edge: got %b want %b", {cif.setup, cif.cpu_stall, cif.flush_valid, cif.busy}, 5'b11_1_0_1);
      end
      for (int c = 0; c < 5; c++) begin
         step();
         checks++;
         if ({cif.cpu_stall, cif.flush_valid} !== 2'b10) begin
            errors++;
            $display("FAIL lower_drain_wait%0d: got %b want 10", c, {cif.cpu_stall, cif.flush_valid});
         end
      end
      cif.cache_idle = 1'b1;
      step();
      for (int k = 0; k < 32; k++) begin
         es = 2'(k / 8);
         ew = 3'(k % 8);
         checks++;
         if ({cif.flush_valid, cif.cpu_stall, cif.setup, cif.flush_set, cif.flush_way} !== {2'b11, 2'd3, es, ew}) begin
            errors++;
            $display("FAIL lower_line%0d: got %b want %b", k,
                     {cif.flush_valid, cif.cpu_stall, cif.setup, cif.flush_set, cif.flush_way}, {2'b11, 2'd3, es, ew});
         end
         step();
      end
      checks++;
      if ({cif.flush_valid, cif.cpu_stall, cif.setup, cif.flush_set, cif.flush_way} !== 9'b0_1_11_00_000) begin
         errors++;
         $display("FAIL lower_switch: got %b want %b",
                  {cif.flush_valid, cif.cpu_stall, cif.setup, cif.flush_set, cif.flush_way}, 9'b0_1_11_00_000);
      end
      step();
      checks++;
      if ({cif.setup, cif.cpu_stall, cif.busy} !== 4'b10_0_0) begin
         errors++;
         $display("FAIL lower_commit: got %b want %b", {cif.setup, cif.cpu_stall, cif.busy}, 4'b10_0_0);
      end
   endtask

   task automatic test_threshold_strict();
      run_accesses(16, 8);
      checks++;
      if ({cif.setup, cif.cpu_stall, cif.busy} !== 4'b10_0_0) begin
         errors++;
         $display("FAIL strict_hi_8: got %b want %b", {cif.setup, cif.cpu_stall, cif.busy}, 4'b10_0_0);
      end
      run_accesses(16, 2);
      checks++;
      if ({cif.setup, cif.cpu_stall, cif.busy} !== 4'b10_0_0) begin
         errors++;
         $display("FAIL strict_lo_2: got %b want %b", {cif.setup, cif.cpu_stall, cif.busy}, 4'b10_0_0);
      end
   endtask

   task automatic test_slow_flush();
      logic [1:0] es;
      logic [2:0] ew;
      cif.flush_done  = 1'b0;
      cif.cache_idle  = 1'b1;
      cif.force_valid = 1'b1;
      cif.force_setup = 2'd0;
      step();
      cif.force_valid = 1'b0;
      checks++;
      if ({cif.cpu_stall, cif.flush_valid, cif.setup} !== 4'b1_0_10) begin
         errors++;
         $display("FAIL slow_drain: got %b want %b", {cif.cpu_stall, cif.flush_valid, cif.setup}, 4'b1_0_10);
      end
      step();
      for (int k = 0; k < 32; k++) begin
         es = 2'(k / 8);
         ew = 3'(k % 8);
         for (int c = 0; c < 4; c++) begin
            checks++;
            if ({cif.flush_valid, cif.cpu_stall, cif.flush_set, cif.flush_way} !== {2'b11, es, ew}) begin
               errors++;
               $display("FAIL slow_line%0d_c%0d: got %b want %b", k, c,
                        {cif.flush_valid, cif.cpu_stall, cif.flush_set, cif.flush_way}, {2'b11, es, ew});
            end
            cif.flush_done  = (c == 3);
            cif.force_valid = (k == 5) && (c == 1);
            cif.force_setup = 2'd3;
            step();
            cif.flush_done  = 1'b0;
            cif.force_valid = 1'b0;
         end
      end
      checks++;
      if ({cif.flush_valid, cif.cpu_stall, cif.setup} !== 4'b0_1_10) begin
         errors++;
         $display("FAIL slow_switch: got %b want %b", {cif.flush_valid, cif.cpu_stall, cif.setup}, 4'b0_1_10);
      end
      step();
      step();
      step();
      checks++;
      if ({cif.setup, cif.cpu_stall, cif.busy} !== 4'b00_0_0) begin
         errors++;
         $display("FAIL slow_commit: got %b want %b", {cif.setup, cif.cpu_stall, cif.busy}, 4'b00_0_0);
      end
   endtask

   task automatic test_reset_mid_sweep();
      cif.flush_done  = 1'b1;
      cif.cache_idle  = 1'b1;
      cif.force_valid = 1'b1;
      cif.force_setup = 2'd2;
      step();
      cif.force_valid = 1'b0;
      step();
      for (int k = 0; k < 10; k++) step();
      checks++;
      if ({cif.flush_valid, cif.flush_set, cif.flush_way} !== 6'b1_01_010) begin
         errors++;
         $display("FAIL mid_sweep_pos: got %b want %b", {cif.flush_valid, cif.flush_set, cif.flush_way}, 6'b1_01_010);
      end
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({cif.flush_valid, cif.cpu_stall, cif.busy, cif.setup, cif.flush_set, cif.flush_way} !== 10'b0_0_0_11_00_000) begin
         errors++;
         $display("FAIL mid_sweep_async: got %b want %b",
                  {cif.flush_valid, cif.cpu_stall, cif.busy, cif.setup, cif.flush_set, cif.flush_way}, 10'b0_0_0_11_00_000);
      end
      #1;
      rst = 1'b0;
      cif.flush_done = 1'b0;
      step();
      step();
      checks++;
      if ({cif.setup, cif.cpu_stall, cif.flush_valid, cif.busy} !== 5'b11_0_0_0) begin
         errors++;
         $display("FAIL mid_sweep_release: got %b want %b", {cif.setup, cif.cpu_stall, cif.flush_valid, cif.busy}, 5'b11_0_0_0);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_threshold_hi_at_max();
      test_collision_epoch();
      test_lower();
      test_threshold_strict();
      test_slow_flush();
      test_reset_mid_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
